fp_norm_round: RTL and testbench

Normalize-and-round stage of the single-precision FP add/sub datapath. It takes the 28-bit post-add mantissa together with the leading-zero count produced by the `leading_zero` block, then:
- shifts the mantissa into normalized position;
- adjusts the exponent;
- rounds to nearest-even;
- packs an IEEE-754 binary32 result with exception flags.

It is a two-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/fp_norm_round.sv | 153 +++++++++++++++
 tb/tb_fp_norm_round.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// Normalize-and-round stage of the binary32 add/sub datapath.
// Two registered stages (normalize, round/pack) with valid/ready handshakes.
module fp_norm_round (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_sign,
  input  logic [7:0]  i_exp,
  input  logic [27:0] i_mant,
  input  logic [7:0]  i_lzc,
  input  logic        i_special,
  input  logic [31:0] i_special_res,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_inexact
);

  logic               s1_load_s;
  logic               s2_load_s;
  logic [7:0]         shamt_s;
  logic [27:0]        shifted_s;
  logic [26:0]        norm_s;
  logic signed [9:0]  norm_exp_s;
  logic               zero_s;

  logic               s1_valid_r;
  logic               s1_sign_r;
  logic               s1_zero_r;
  logic               s1_special_r;
  logic [31:0]        s1_special_res_r;
  logic [26:0]        s1_n_r;
  logic signed [9:0]  s1_exp_r;

  logic               round_up_s;
  logic [24:0]        sum_s;
  logic signed [9:0]  rnd_exp_s;
  logic [22:0]        frac_s;
  logic [31:0]        res_s;
  logic               ovf_s;
  logic               unf_s;
  logic               inx_s;

  logic               s2_valid_r;
  logic [31:0]        result_r;
  logic               ovf_r;
  logic               unf_r;
  logic               inx_r;

  // A stage loads when empty or when its contents move on this cycle.
  assign s2_load_s = !s2_valid_r | i_ready;
  assign s1_load_s = !s1_valid_r | s2_load_s;
  assign o_ready   = s1_load_s;

  // Normalize: lzc=0 means a carry, so shift right one and fold the lost bit into sticky.
  always_comb begin
    shamt_s    = 8'd0;
    shifted_s  = 28'd0;
    norm_s     = 27'd0;
    norm_exp_s = 10'sd0;
    zero_s     = 1'b0;
    if (i_lzc == 8'd0) begin
      norm_s     = {i_mant[27:2], i_mant[1] | i_mant[0]};
      norm_exp_s = $signed({2'b00, i_exp}) + 10'sd1;
    end else if (i_lzc <= 8'd27) begin
      shamt_s    = i_lzc - 8'd1;
      shifted_s  = i_mant << shamt_s;
      norm_s     = shifted_s[26:0];
      norm_exp_s = $signed({2'b00, i_exp}) - $signed({2'b00, shamt_s});
    end else begin
      zero_s = 1'b1;
    end
  end

  // Stage 1 register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_r       <= 1'b0;
      s1_sign_r        <= 1'b0;
      s1_zero_r        <= 1'b0;
      s1_special_r     <= 1'b0;
      s1_special_res_r <= 32'd0;
      s1_n_r           <= 27'd0;
      s1_exp_r         <= 10'sd0;
    end else if (s1_load_s) begin
      s1_valid_r       <= i_valid;
      s1_sign_r        <= i_sign;
      s1_zero_r        <= zero_s;
      s1_special_r     <= i_special;
      s1_special_res_r <= i_special_res;
      s1_n_r           <= norm_s;
      s1_exp_r         <= norm_exp_s;
    end
  end

  assign round_up_s = s1_n_r[2] & (s1_n_r[1] | s1_n_r[0] | s1_n_r[3]);
  assign sum_s      = {1'b0, s1_n_r[26:3]} + {24'd0, round_up_s};
  assign rnd_exp_s  = sum_s[24] ? (s1_exp_r + 10'sd1) : s1_exp_r;
  assign frac_s     = sum_s[24] ? sum_s[23:1] : sum_s[22:0];

  // Round/pack with priority special > zero > underflow > overflow > normal.
  always_comb begin
    res_s = 32'd0;
    ovf_s = 1'b0;
    unf_s = 1'b0;
    inx_s = 1'b0;
    if (s1_special_r) begin
      res_s = s1_special_res_r;
    end else if (s1_zero_r) begin
      res_s = 32'd0;
    end else if (s1_exp_r <= 10'sd0) begin
      res_s = {s1_sign_r, 31'd0};
      unf_s = 1'b1;
      inx_s = 1'b1;
    end else if (rnd_exp_s >= 10'sd255) begin
      res_s = {s1_sign_r, 8'hFF, 23'd0};
      ovf_s = 1'b1;
      inx_s = 1'b1;
    end else begin
      res_s = {s1_sign_r, rnd_exp_s[7:0], frac_s};
      inx_s = |s1_n_r[2:0];
    end
  end

  // Stage 2 register drives the outputs; held while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid_r <= 1'b0;
      result_r   <= 32'd0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      inx_r      <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= res_s;
        ovf_r    <= ovf_s;
        unf_r    <= unf_s;
        inx_r    <= inx_s;
      end
    end
  end

  assign o_valid     = s2_valid_r;
  assign o_result    = result_r;
  assign o_overflow  = ovf_r;
  assign o_underflow = unf_r;
  assign o_inexact   = inx_r;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: hand-computed vectors, backpressure and reset.
module tb_fp_norm_round;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [27:0] i_mant;
  logic [7:0]  i_lzc;
  logic        i_special;
  logic [31:0] i_special_res;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_overflow;
  logic        o_underflow;
  logic        o_inexact;

  int n_checks = 0;
  int n_fail   = 0;

  fp_norm_round dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_sign        (i_sign),
    .i_exp         (i_exp),
    .i_mant        (i_mant),
    .i_lzc         (i_lzc),
    .i_special     (i_special),
    .i_special_res (i_special_res),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_result      (o_result),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow),
    .o_inexact     (o_inexact)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] m,
                       input logic [7:0] l, input logic sp, input logic [31:0] spr);
    i_valid = 1'b1; i_sign = s; i_exp = e; i_mant = m; i_lzc = l;
    i_special = sp; i_special_res = spr;
  endtask

  // One word through an unstalled pipe; result must appear exactly 2 cycles later.
  task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                         input logic [27:0] m, input logic [7:0] l, input logic sp,
                         input logic [31:0] spr, input logic [31:0] exp_res,
                         input logic [2:0] exp_flags);
    @(negedge i_clk);
    drive(s, e, m, l, sp, spr);
    #1 chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    #1 chk({tag, "_lat1"}, {31'd0, o_valid}, 32'd0);
    @(negedge i_clk);
    #1;
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_result"}, o_result, exp_res);
    chk({tag, "_flags"}, {29'd0, o_overflow, o_underflow, o_inexact}, {29'd0, exp_flags});
  endtask

  logic [31:0] got_q[$];
  logic [31:0] held;
  int          sent;
  int          seen;

  initial begin
    i_rst = 1'b1; i_ready = 1'b1;
    drive(1'b0, 8'd0, 28'd0, 8'd0, 1'b0, 32'd0);
    i_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_flags", {29'd0, o_overflow, o_underflow, o_inexact}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    i_rst = 1'b0;

    // flags order: {overflow, underflow, inexact}
    run_vec("one",      1'b0, 8'd127, 28'h4000000, 8'd1,  1'b0, 32'd0, 32'h3F800000, 3'b000);
    run_vec("neg_one",  1'b1, 8'd127, 28'h4000000, 8'd1,  1'b0, 32'd0, 32'hBF800000, 3'b000);
    run_vec("carry",    1'b0, 8'd127, 28'h8000000, 8'd0,  1'b0, 32'd0, 32'h40000000, 3'b000);
    run_vec("carry_st", 1'b0, 8'd127, 28'h8000001, 8'd0,  1'b0, 32'd0, 32'h40000000, 3'b001);
    run_vec("half",     1'b0, 8'd127, 28'h2000000, 8'd2,  1'b0, 32'd0, 32'h3F000000, 3'b000);
    run_vec("cancel",   1'b1, 8'd127, 28'h0000000, 8'd28, 1'b0, 32'd0, 32'h00000000, 3'b000);
    run_vec("tie_even", 1'b0, 8'd127, 28'h4000004, 8'd1,  1'b0, 32'd0, 32'h3F800000, 3'b001);
    run_vec("tie_odd",  1'b0, 8'd127, 28'h400000C, 8'd1,  1'b0, 32'd0, 32'h3F800002, 3'b001);
    run_vec("rnd_carry",1'b0, 8'd127, 28'h7FFFFFC, 8'd1,  1'b0, 32'd0, 32'h40000000, 3'b001);
    run_vec("ovf",      1'b0, 8'd254, 28'h8000000, 8'd0,  1'b0, 32'd0, 32'h7F800000, 3'b101);
    run_vec("ovf_neg",  1'b1, 8'd254, 28'h8000000, 8'd0,  1'b0, 32'd0, 32'hFF800000, 3'b101);
    run_vec("unf",      1'b0, 8'd10,  28'h0000008, 8'd24, 1'b0, 32'd0, 32'h00000000, 3'b011);
    run_vec("unf_neg",  1'b1, 8'd10,  28'h0000008, 8'd24, 1'b0, 32'd0, 32'h80000000, 3'b011);
    run_vec("special",  1'b0, 8'd254, 28'h8000000, 8'd0,  1'b1, 32'h7FC00000, 32'h7FC00000, 3'b000);

    // Illegal lzc: result is don't-care, but the word must still come out.
    @(negedge i_clk);
    drive(1'b0, 8'd100, 28'h1234567, 8'd40, 1'b0, 32'd0);
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    #1 chk("bad_lzc_valid", {31'd0, o_valid}, 32'd1);

    // Backpressure: 5 words (exponents 120..124), i_ready low for 3 cycles.
    @(negedge i_clk);
    i_ready = 1'b0;
    drive(1'b0, 8'd120, 28'h4000000, 8'd1, 1'b0, 32'd0);
    #1 chk("bp_ready0", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    drive(1'b0, 8'd121, 28'h4000000, 8'd1, 1'b0, 32'd0);
    #1 chk("bp_ready1", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    drive(1'b0, 8'd122, 28'h4000000, 8'd1, 1'b0, 32'd0);
    #1;
    chk("bp_full_ready", {31'd0, o_ready}, 32'd0);
    chk("bp_stall_valid", {31'd0, o_valid}, 32'd1);
    chk("bp_stall_res", o_result, 32'h3C000000);
    held = o_result;
    @(negedge i_clk);
    chk("bp_stable", o_result, 32'h3C000000);
    chk("bp_stable_held", o_result, held);
    i_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
    got_q.push_back(o_result);
    sent = 3;
    for (int c = 0; c < 12 && got_q.size() < 5; c++) begin
      @(negedge i_clk);
      if (sent < 5) begin
        drive(1'b0, 8'(120 + sent), 28'h4000000, 8'd1, 1'b0, 32'd0);
        sent++;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (o_valid) got_q.push_back(o_result);
    end
    i_valid = 1'b0;
    chk("bp_count", 32'(got_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got_q.size())
        chk($sformatf("bp_word%0d", k), got_q[k], {1'b0, 8'(120 + k), 23'd0});
    end
    @(negedge i_clk);
    #1 chk("bp_no_dup", {31'd0, o_valid}, 32'd0);

    // Reset with two words in flight (stalled so neither is consumed).
    @(negedge i_clk);
    i_ready = 1'b0;
    drive(1'b0, 8'd200, 28'h4000000, 8'd1, 1'b0, 32'd0);
    @(negedge i_clk);
    drive(1'b1, 8'd201, 28'h4000000, 8'd1, 1'b0, 32'd0);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    #1;
    chk("rst2_valid", {31'd0, o_valid}, 32'd0);
    chk("rst2_result", o_result, 32'd0);
    chk("rst2_ready", {31'd0, o_ready}, 32'd1);
    i_rst = 1'b0;
    i_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      #1;
      if (o_valid) seen++;
    end
    chk("rst2_flushed", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
